// File: rtl/sar_cycle_sequencer.sv
// Synchronous SAR cycle sequencer: counts comparator RDY edges, builds CF/D,
// latches DOUT with a VALID strobe, flags FINAL and a missing-RDY TIMEOUT.
//
// Ports:
//   CLK, RSTN      clock, async-assert active-low reset (release synchronised)
//   CKS            sample clock, high = conversion phase
//   RDY, COMP      comparator ready (rising edge) and decision, async to CLK
//   CF             thermometer cycle flags
//   D              live SAR bits, D[NBITS-1] is the MSB
//   DOUT, VALID    last result and its one-cycle update strobe
//   FINAL, TIMEOUT conversion complete / RDY edge missing, held until CKS low
module sar_cycle_sequencer #(
  parameter int NBITS       = 9,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 63
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             CKS,
  input  logic             RDY,
  input  logic             COMP,
  output logic [NBITS-1:0] CF,
  output logic [NBITS-1:0] D,
  output logic             FINAL,
  output logic [NBITS-1:0] DOUT,
  output logic             VALID,
  output logic             TIMEOUT
);

  localparam int KW = $clog2(NBITS + 1);
  localparam logic [KW-1:0] KLAST = KW'(NBITS - 1);
  localparam logic [7:0] TLAST = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE,
    ERR
  } state_t;

  logic [1:0] rst_sq;
  logic       run;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) rst_sq <= '0;
    else       rst_sq <= {rst_sq[0], 1'b1};
  end

  assign run = rst_sq[1];

  logic [SYNC_STAGES-1:0] cks_sy;
  logic [SYNC_STAGES-1:0] rdy_sy;
  logic [SYNC_STAGES-1:0] comp_sy;
  logic                   rdy_d;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cks_sy  <= '0;
      rdy_sy  <= '0;
      comp_sy <= '0;
      rdy_d   <= 1'b0;
    end else begin
      cks_sy  <= {cks_sy[SYNC_STAGES-2:0], CKS};
      rdy_sy  <= {rdy_sy[SYNC_STAGES-2:0], RDY};
      comp_sy <= {comp_sy[SYNC_STAGES-2:0], COMP};
      rdy_d   <= rdy_sy[SYNC_STAGES-1];
    end
  end

  logic cks_s;
  logic comp_s;
  logic rdy_edge;

  assign cks_s    = cks_sy[SYNC_STAGES-1];
  assign comp_s   = comp_sy[SYNC_STAGES-1];
  assign rdy_edge = rdy_sy[SYNC_STAGES-1] & ~rdy_d;

  state_t           state_q, state_n;
  logic [NBITS-1:0] cf_q, cf_n;
  logic [NBITS-1:0] d_q, d_n;
  logic [NBITS-1:0] dout_q, dout_n;
  logic [KW-1:0]    k_q, k_n;
  logic [7:0]       timer_q, timer_n;
  logic             valid_q, valid_n;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      cf_q    <= '0;
      d_q     <= '0;
      dout_q  <= '0;
      k_q     <= '0;
      timer_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_n;
      cf_q    <= cf_n;
      d_q     <= d_n;
      dout_q  <= dout_n;
      k_q     <= k_n;
      timer_q <= timer_n;
      valid_q <= valid_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cf_n    = cf_q;
    d_n     = d_q;
    dout_n  = dout_q;
    k_n     = k_q;
    timer_n = timer_q;
    valid_n = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cks_s) state_n = CONV;
      end
      CONV: begin
        if (!cks_s) begin
          state_n = IDLE;
        end else if (rdy_edge) begin
          timer_n = '0;
          k_n     = k_q + KW'(1);
          for (int i = 0; i < NBITS; i++) begin
            if (k_q == KW'(i)) begin
              cf_n[i]           = 1'b1;
              d_n[NBITS-1-i]    = comp_s;
            end
          end
          if (k_q == KLAST) begin
            state_n = DONE;
            dout_n  = d_n;
            valid_n = 1'b1;
          end
        end else if (timer_q == TLAST) begin
          state_n = ERR;
        end else begin
          timer_n = timer_q + 8'd1;
        end
      end
      DONE, ERR: begin
        if (!cks_s) state_n = IDLE;
      end
    endcase
    // Held in reset until the synchronised release arrives.
    if (!run) begin
      state_n = IDLE;
      dout_n  = '0;
      valid_n = 1'b0;
    end
    // Every entry into (and stay in) IDLE clears the per-conversion state.
    if (state_n == IDLE) begin
      cf_n    = '0;
      d_n     = '0;
      k_n     = '0;
      timer_n = '0;
    end
  end

  assign CF      = cf_q;
  assign D       = d_q;
  assign DOUT    = dout_q;
  assign VALID   = valid_q;
  assign FINAL   = (state_q == DONE) || (state_q == ERR);
  assign TIMEOUT = (state_q == ERR);

endmodule

// File: doc/sar_cycle_sequencer.md
# sar_cycle_sequencer

Parametrised, fully synchronous successor to the asynchronous cyclic-flag shift chain in the SAR ADC digital back-end. It counts comparator-ready events during the conversion phase of CKS and produces the thermometer cycle flags and FINAL. It also resolves the SAR code MSB-first from the comparator decision and latches the result with a one-cycle VALID strobe. It adds a missing-RDY timeout, which the legacy chain lacks, and sits between the dynamic comparator and the capacitive-DAC switch drivers.

## Interface
- NBITS, 9, resolution: number of comparator cycles and of CF/D/DOUT bits (2..16)
- SYNC_STAGES, 2, synchroniser depth applied to CKS, RDY, COMP (>=2)
- TIMEOUT_CYC, 63, CLK cycles allowed between conversion start or last accepted RDY edge and the next one (1..255)

- CLK  input  1  system clock; all state changes on rising edge
- RSTN  input  1  reset, asynchronous assert, active-low
- CKS  input  1  sample clock; high = conversion phase, low = sampling/clear
- RDY  input  1  comparator ready, asynchronous to CLK; rising edge = decision available
- COMP  input  1  comparator decision, stable while RDY high
- CF  output  NBITS  thermometer cycle flags; CF[k]=1 once k+1 decisions taken
- D  output  NBITS  live SAR bits to DAC switches; D[NBITS-1] is MSB
- FINAL  output  1  conversion complete (normal or timeout), held until CKS low
- DOUT  output  NBITS  last valid conversion result
- VALID  output  1  one-cycle strobe when DOUT updates
- TIMEOUT  output  1  sticky per conversion: RDY edge missing

## Operation
- CKS, RDY, COMP each pass through SYNC_STAGES flops; rdy_edge = synced RDY high and its one-cycle-delayed copy low.
- States: IDLE, CONV, DONE, ERR.
- IDLE: CF=0, D=0, FINAL=0, TIMEOUT=0, bit index k=0, timer=0. Synced CKS high -> CONV.
- CONV: on rdy_edge, D[NBITS-1-k] <= synced COMP, CF[k] <= 1, k <= k+1, timer <= 0. The edge with k=NBITS-1 -> DONE. Otherwise timer increments each cycle; at timer=TIMEOUT_CYC-1 with no edge -> ERR.
- DONE: entry cycle: DOUT <= D, VALID=1 for that cycle only, FINAL=1. Further rdy_edges ignored. Synced CKS low -> IDLE.
- ERR: FINAL=1, TIMEOUT=1; DOUT keeps previous value, no VALID. Synced CKS low -> IDLE.
- Synced CKS low in CONV (abort): -> IDLE next cycle, no VALID, DOUT unchanged.
- An rdy_edge and CKS low in the same cycle: CKS wins; no bit captured.
- A timeout and an rdy_edge in the same cycle: the edge wins; timer resets.
- rdy_edge while in IDLE: ignored.
- D bits below the current index stay 0 (trial-bit drive is the DAC's job); CF is monotonic within a conversion.

## Timing
- Reset (RSTN low, immediate): state IDLE; CF, D, DOUT = 0; FINAL, VALID, TIMEOUT = 0. Release is synchronised internally; the first state change is no earlier than the second CLK edge after RSTN rises.
- RDY rise to CF/D update: SYNC_STAGES+1 CLK edges.
- Last rdy_edge to FINAL, VALID, DOUT: +1 CLK edge.
- CKS fall to CF/D/FINAL clear: SYNC_STAGES+1 CLK edges.
- CKS rise to CONV: SYNC_STAGES+1 CLK edges; the timer starts at 0 on the entry cycle.
- Minimum RDY high and low time: 2 CLK periods each, or edges may be lost (not flagged).
- Timeout fires exactly TIMEOUT_CYC cycles after CONV entry or after the last accepted edge.

## Test plan
- Reset mid-conversion: NBITS=9, assert RSTN low after 4 RDY edges -> all outputs 0 at once; after release plus CKS high, a fresh conversion proceeds.
- Nominal conversion: COMP sequence 1,0,1,1,0,0,1,0,1 over 9 RDY pulses -> CF fills 0x001..0x1FF; DOUT=9'h165; VALID high exactly 1 cycle; FINAL held until CKS low plus 3 cycles.
- Abort: CKS low after 5 edges -> IDLE, CF=0, no VALID, DOUT retains the prior 9'h165.
- Timeout: TIMEOUT_CYC=8, stop RDY after 3 edges -> TIMEOUT=1 and FINAL=1 at exactly 8 cycles after the 3rd accepted edge; DOUT unchanged; both clear after CKS low.
- Extra and early edges: a 10th RDY pulse in DONE and RDY pulses in IDLE -> CF, D, DOUT unchanged.
- Parameter sweep: NBITS=4, SYNC_STAGES=3, all-ones COMP -> DOUT=4'hF; RDY-to-CF latency measured as 4 CLK edges.
